// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle control FSM for a MIPS subset (ADD, SUB, AND, OR, LW, SW, BEQ).
//   It steps the datapath through FETCH/DECODE/EXEC/MEM/WB and drives one-cycle
//   enables. The MEM states wait on a data-memory ready handshake. The block
//   counts retired instructions and halts when it decodes an illegal instruction.
//
// Parameters
//   CNT_W     width of the retired-instruction counter (wraps modulo 2^CNT_W)
//   MEM_WAIT  1: MEM_RD/MEM_WR wait for mem_ready; 0: single-cycle memory
//
// Ports
//   clk, rst       rising-edge clock; asynchronous active-high reset
//   opcode, funct  instruction fields, stable from DECODE until the next FETCH
//   zero           ALU result equals zero (branch condition)
//   mem_ready      data memory has completed the current access
//   ir_we, pc_we   instruction register / PC load enables
//   pc_src         0: PC+4, 1: branch target
//   alu_src_b      0: Rt, 1: sign-extended immediate
//   alu_op         00 add, 01 sub, 10 use funct
//   reg_we, reg_dst, mem_to_reg   register-file write controls
//   mem_re, mem_we data memory read / write requests
//   state          current state encoding (debug)
//   illegal        sticky flag: an unsupported opcode or funct was decoded
//   retired        count of completed instructions
module mips_multicycle_ctrl #(
   parameter int unsigned CNT_W    = 32,
   parameter bit          MEM_WAIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_we,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             mem_re,
   output logic             mem_we,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

   localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
   localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
   localparam logic [OP_W-1:0] FN_AND = 6'b100100;
   localparam logic [OP_W-1:0] FN_OR  = 6'b100101;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_R_WB     = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_HALT     = 4'd9
   } state_e;

   state_e            state_q, state_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              funct_ok;
   logic              mem_done;

   assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                     (funct == FN_AND) || (funct == FN_OR);

   // With MEM_WAIT=0 the memory is assumed to finish in one cycle
   assign mem_done = (MEM_WAIT == 1'b0) || mem_ready;

   // State, sticky illegal flag and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      retired_d  = retired_q;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = ALU_ADD;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_src  = 1'b0;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if ((opcode == OP_RTYPE) && funct_ok) begin
               state_d = S_EXEC_R;
            end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               state_d = S_MEM_ADDR;
            end else if (opcode == OP_BEQ) begin
               state_d = S_BRANCH;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_EXEC_R: begin
            alu_src_b = 1'b0;
            alu_op    = ALU_FUNCT;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_we     = 1'b1;
            reg_dst    = 1'b1;
            mem_to_reg = 1'b0;
            alu_op     = ALU_FUNCT;
            retired_d  = retired_q + CNT_W'(1);
            state_d    = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_ADD;
            state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_re    = 1'b1;
            alu_src_b = 1'b1;
            if (mem_done) begin
               state_d = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            reg_we     = 1'b1;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b1;
            retired_d  = retired_q + CNT_W'(1);
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_we    = 1'b1;
            alu_src_b = 1'b1;
            if (mem_done) begin
               retired_d = retired_q + CNT_W'(1);
               state_d   = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_b = 1'b0;
            alu_op    = ALU_SUB;
            pc_we     = zero;
            pc_src    = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Reset parks the FSM in FETCH; suppress its enables (drops in-flight stores)
      if (rst) begin
         ir_we  = 1'b0;
         pc_we  = 1'b0;
         pc_src = 1'b0;
         reg_we = 1'b0;
         mem_re = 1'b0;
         mem_we = 1'b0;
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a default-parameter instance and a
// CNT_W=4 / MEM_WAIT=0 instance for counter wrap with single-cycle memory.
module tb_mips_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        ir_we, pc_we, pc_src, alu_src_b, reg_we, reg_dst, mem_to_reg;
   logic        mem_re, mem_we, illegal;
   logic [1:0]  alu_op;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        rst_6;
   logic [5:0]  opcode_6;
   logic [5:0]  funct_6;
   logic        zero_6;
   logic        mem_ready_6;
   logic        ir_we_6, pc_we_6, pc_src_6, alu_src_b_6, reg_we_6, reg_dst_6, mem_to_reg_6;
   logic        mem_re_6, mem_we_6, illegal_6;
   logic [1:0]  alu_op_6;
   logic [3:0]  state_6;
   logic [3:0]  retired_6;

   int n_checks = 0;
   int n_errors = 0;
   int excl_viol = 0;

   mips_multicycle_ctrl #(.CNT_W(32), .MEM_WAIT(1'b1)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .mem_re(mem_re), .mem_we(mem_we), .state(state),
      .illegal(illegal), .retired(retired)
   );

   mips_multicycle_ctrl #(.CNT_W(4), .MEM_WAIT(1'b0)) u_dut6 (
      .clk(clk), .rst(rst_6), .opcode(opcode_6), .funct(funct_6), .zero(zero_6),
      .mem_ready(mem_ready_6), .ir_we(ir_we_6), .pc_we(pc_we_6), .pc_src(pc_src_6),
      .alu_src_b(alu_src_b_6), .alu_op(alu_op_6), .reg_we(reg_we_6), .reg_dst(reg_dst_6),
      .mem_to_reg(mem_to_reg_6), .mem_re(mem_re_6), .mem_we(mem_we_6), .state(state_6),
      .illegal(illegal_6), .retired(retired_6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mutual-exclusion watch on the main instance
   always @(negedge clk) begin
      if ((mem_re && mem_we) || (reg_we && pc_we)) excl_viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Run one BEQ from FETCH and check the BRANCH-state outputs
   task automatic do_beq(input logic z, input logic [31:0] ret_after);
      opcode = 6'b000100; funct = 6'b000000; zero = z;
      check("beq_fetch", 32'(state), 32'd0);
      tick(); check("beq_decode", 32'(state), 32'd1);
      tick(); check("beq_state", 32'(state), 32'd8);
      check("beq_pc_we", 32'(pc_we), 32'(z));
      check("beq_pc_src", 32'(pc_src), 32'd1);
      check("beq_alu_op", 32'(alu_op), 32'd1);
      tick(); check("beq_back", 32'(state), 32'd0);
      check("beq_retired", retired, ret_after);
   endtask

   initial begin
      int cyc;
      int re_seen;
      int we_seen;
      rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      rst_6 = 1'b1; opcode_6 = 6'b101011; funct_6 = 6'd0; zero_6 = 1'b0; mem_ready_6 = 1'b0;
      tick(); tick();

      // Reset state
      check("rst_state", 32'(state), 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_ir_we", 32'(ir_we), 32'd0);
      check("rst_pc_we", 32'(pc_we), 32'd0);

      // ADD
      funct = 6'b100000;
      rst = 1'b0;
      #1;
      check("add_fetch_ir_we", 32'(ir_we), 32'd1);
      check("add_fetch_pc_we", 32'(pc_we), 32'd1);
      tick(); check("add_s1", 32'(state), 32'd1); check("add_s1_reg_we", 32'(reg_we), 32'd0);
      tick(); check("add_s2", 32'(state), 32'd2); check("add_s2_alu_op", 32'(alu_op), 32'd2);
      check("add_s2_reg_we", 32'(reg_we), 32'd0);
      tick(); check("add_s3", 32'(state), 32'd3); check("add_reg_we", 32'(reg_we), 32'd1);
      check("add_reg_dst", 32'(reg_dst), 32'd1); check("add_m2r", 32'(mem_to_reg), 32'd0);
      check("add_ret_before", retired, 32'd0);
      tick(); check("add_back", 32'(state), 32'd0); check("add_retired", retired, 32'd1);

      // LW with mem_ready low for three MEM_RD cycles
      opcode = 6'b100011; mem_ready = 1'b0; cyc = 1;
      tick(); cyc++; check("lw_decode", 32'(state), 32'd1);
      tick(); cyc++; check("lw_addr", 32'(state), 32'd4); check("lw_addr_srcb", 32'(alu_src_b), 32'd1);
      tick(); cyc++;
      for (int i = 0; i < 4; i++) begin
         check("lw_rd_state", 32'(state), 32'd5);
         check("lw_mem_re", 32'(mem_re), 32'd1);
         if (i == 3) mem_ready = 1'b1;
         tick(); cyc++;
      end
      mem_ready = 1'b0;
      check("lw_wb", 32'(state), 32'd6); check("lw_reg_we", 32'(reg_we), 32'd1);
      check("lw_m2r", 32'(mem_to_reg), 32'd1); check("lw_reg_dst", 32'(reg_dst), 32'd0);
      check("lw_wb_mem_re", 32'(mem_re), 32'd0);
      tick();
      check("lw_cycles", 32'(cyc), 32'd8);
      check("lw_back", 32'(state), 32'd0); check("lw_retired", retired, 32'd2);

      // BEQ taken / not taken
      do_beq(1'b1, 32'd3);
      do_beq(1'b0, 32'd4);

      // SW with memory ready at once: 4 cycles
      opcode = 6'b101011; mem_ready = 1'b1;
      tick(); tick(); check("sw_addr", 32'(state), 32'd4);
      tick(); check("sw_wr", 32'(state), 32'd7); check("sw_mem_we", 32'(mem_we), 32'd1);
      tick(); check("sw_back", 32'(state), 32'd0); check("sw_retired", retired, 32'd5);

      // Reset mid-MEM_WR with memory stalled
      mem_ready = 1'b0;
      tick(); tick(); tick(); check("rstw_wr", 32'(state), 32'd7);
      tick(); check("rstw_wait", 32'(state), 32'd7); check("rstw_we_before", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check("rstw_mem_we", 32'(mem_we), 32'd0);
      check("rstw_state", 32'(state), 32'd0);
      check("rstw_retired", retired, 32'd0);
      tick(); rst = 1'b0;

      // One BEQ, then illegal opcode 000010
      do_beq(1'b0, 32'd1);
      opcode = 6'b000010;
      tick(); check("ill_decode", 32'(illegal), 32'd0);
      tick(); check("ill_halt", 32'(state), 32'd9); check("ill_flag", 32'(illegal), 32'd1);
      mem_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("ill_still_halt", 32'(state), 32'd9);
      check("ill_retired", retired, 32'd1);
      check("ill_pc_we", 32'(pc_we), 32'd0);
      check("ill_ir_we", 32'(ir_we), 32'd0);
      mem_ready = 1'b0;
      rst = 1'b1; #1;
      check("ill_rst_flag", 32'(illegal), 32'd0);
      check("ill_rst_state", 32'(state), 32'd0);
      tick(); rst = 1'b0;

      // Unsupported R-type funct (SLT) is illegal
      opcode = 6'b000000; funct = 6'b101010;
      tick(); tick();
      check("slt_halt", 32'(state), 32'd9); check("slt_flag", 32'(illegal), 32'd1);
      rst = 1'b1;

      // 17 SW on the CNT_W=4, MEM_WAIT=0 instance
      re_seen = 0; we_seen = 0;
      rst_6 = 1'b0;
      for (int i = 0; i < 17 * 4; i++) begin
         #1;
         if (mem_re_6) re_seen++;
         if (mem_we_6) we_seen++;
         tick();
      end
      check("w6_state", 32'(state_6), 32'd0);
      check("w6_retired", 32'(retired_6), 32'd1);
      check("w6_mem_re", 32'(re_seen), 32'd0);
      check("w6_mem_we", 32'(we_seen), 32'd17);

      check("exclusive_enables", 32'(excl_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
